// File: rtl/empaquetador_2a8.sv
// empaquetador_2a8: packs four consecutive valid 2-bit symbols from the
// 2:1 mux stage into one 8-bit word. The word is offered downstream with a
// valid/ready handshake and a sticky overflow flag.
//
// Optional build macro: TRANS_COUNT_EN
//   When defined, adds fall_cnt0/fall_cnt1 outputs that count falling
//   transitions of bit 0 / bit 1 across consecutive accepted symbols.
//   When undefined, those ports and their logic are absent and everything
//   else behaves identically.
module empaquetador_2a8 #(
    parameter int SYM_W = 2,
    parameter int SYMS  = 4
`ifdef TRANS_COUNT_EN
    ,
    parameter int CNT_W = 6
`endif
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    valid_in,
    input  logic [SYM_W-1:0]        data_in,
    input  logic                    ready_in,
    output logic [SYM_W*SYMS-1:0]   data_out,
    output logic                    valid_out,
    output logic                    overflow,
    output logic [1:0]              sym_count
`ifdef TRANS_COUNT_EN
    ,
    output logic [CNT_W-1:0]        fall_cnt0,
    output logic [CNT_W-1:0]        fall_cnt1
`endif
);

    // Slot index of the symbol that completes a word.
    localparam logic [1:0] LAST_SLOT = 2'(SYMS - 1);

    // Output side: FREE means no unconsumed word, HELD means data_out
    // carries a word the consumer has not taken yet.
    typedef enum logic {
        FREE = 1'b0,
        HELD = 1'b1
    } out_state_t;

    out_state_t out_state;

    // Slots 0..SYMS-2 are stored here; the last slot is never stored
    // because it is taken straight from data_in on the completing edge.
    logic [SYM_W*(SYMS-1)-1:0] fill_reg;

    logic                      complete;
    logic [SYM_W*SYMS-1:0]     word;

    // A word completes on the edge that accepts the last slot; the
    // incoming symbol lands in the top slot of the assembled word.
    assign complete = valid_in && (sym_count == LAST_SLOT);
    assign word     = {data_in, fill_reg};

    assign valid_out = (out_state == HELD);

    // Fill side: write each accepted symbol into its slot and advance the
    // slot pointer; the fill register is cleared once a word is formed so
    // a stale partial word never lingers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fill_reg  <= '0;
            sym_count <= '0;
        end else if (valid_in) begin
            if (complete) begin
                fill_reg  <= '0;
                sym_count <= '0;
            end else begin
                for (int k = 0; k < SYMS - 1; k++) begin
                    if (sym_count == 2'(k)) begin
                        fill_reg[k*SYM_W +: SYM_W] <= data_in;
                    end
                end
                sym_count <= sym_count + 2'd1;
            end
        end
    end

    // Output FSM: load completed words when the output is free or is being
    // consumed on the same edge (no bubble), otherwise drop the word and
    // raise the sticky overflow flag. data_out keeps its last value after
    // consumption.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_state <= FREE;
            data_out  <= '0;
            overflow  <= 1'b0;
        end else begin
            case (out_state)
                FREE: begin
                    if (complete) begin
                        data_out  <= word;
                        out_state <= HELD;
                    end
                end
                HELD: begin
                    if (complete) begin
                        if (ready_in) begin
                            data_out  <= word;
                            out_state <= HELD;
                        end else begin
                            overflow  <= 1'b1;
                        end
                    end else if (ready_in) begin
                        out_state <= FREE;
                    end
                end
                default: begin
                    out_state <= FREE;
                end
            endcase
        end
    end

`ifdef TRANS_COUNT_EN
    logic [SYM_W-1:0] last_sym;

    // Transition counters: compare each accepted symbol with the previous
    // accepted one and count 1->0 changes per bit. Independent of the
    // handshake, so dropped words still contribute.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_sym  <= '0;
            fall_cnt0 <= '0;
            fall_cnt1 <= '0;
        end else if (valid_in) begin
            last_sym <= data_in;
            if (last_sym[0] && !data_in[0]) begin
                fall_cnt0 <= fall_cnt0 + 1'b1;
            end
            if (last_sym[1] && !data_in[1]) begin
                fall_cnt1 <= fall_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_empaquetador_2a8.sv
// tb_empaquetador_2a8: directed plus randomized bench for empaquetador_2a8.
// A queue-based reference model tracks the expected packed word, handshake
// and overflow state. Build with +define+TRANS_COUNT_EN to also cover the
// transition counters.
module tb_empaquetador_2a8;

    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic       valid_in = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       ready_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       overflow;
    logic [1:0] sym_count;
`ifdef TRANS_COUNT_EN
    logic [5:0] fall_cnt0;
    logic [5:0] fall_cnt1;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    int q[$];
    int m_data;
    int m_valid;
    int m_ovf;
    int m_prev;
    int m_fall0;
    int m_fall1;

    empaquetador_2a8 dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .overflow  (overflow),
        .sym_count (sym_count)
`ifdef TRANS_COUNT_EN
        ,
        .fall_cnt0 (fall_cnt0),
        .fall_cnt1 (fall_cnt1)
`endif
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model reset: everything returns to zero, partial word discarded.
    task automatic modelReset();
        q.delete();
        m_data  = 0;
        m_valid = 0;
        m_ovf   = 0;
        m_prev  = 0;
        m_fall0 = 0;
        m_fall1 = 0;
    endtask

    // Model one rising edge with the inputs that were presented to it.
    task automatic modelStep(input logic v, input logic [1:0] d, input logic r);
        int word;
        bit done;
        done = 0;
        word = 0;
        if (v) begin
            if (m_prev % 2 == 1 && d % 2 == 0) m_fall0 = (m_fall0 + 1) % 64;
            if (m_prev / 2 == 1 && d / 2 == 0) m_fall1 = (m_fall1 + 1) % 64;
            m_prev = int'(d);
            q.push_back(int'(d));
            if (q.size() == 4) begin
                word = q[0] + q[1] * 4 + q[2] * 16 + q[3] * 64;
                q.delete();
                done = 1;
            end
        end
        if (done) begin
            if (m_valid == 0 || r) begin
                m_data  = word;
                m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_valid == 1 && r) begin
            m_valid = 0;
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compareAll();
        checkOutput("data_out", 32'(data_out), 32'(m_data));
        checkOutput("valid_out", 32'(valid_out), 32'(m_valid));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("sym_count", 32'(sym_count), 32'(q.size()));
`ifdef TRANS_COUNT_EN
        checkOutput("fall_cnt0", 32'(fall_cnt0), 32'(m_fall0));
        checkOutput("fall_cnt1", 32'(fall_cnt1), 32'(m_fall1));
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then check 1 ns later.
    task automatic applyStimulus(input logic v, input logic [1:0] d, input logic r);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        @(posedge clk);
        modelStep(v, d, r);
        #1;
        compareAll();
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic doReset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = 2'b00;
        #1;
        modelReset();
        compareAll();
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        logic [1:0] syms8 [8];
        syms8 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

        modelReset();
        #2;
        doReset();

        // Basic pack with directed constant checks
        applyStimulus(1'b1, 2'b01, 1'b1);
        checkOutput("basic_cnt1", 32'(sym_count), 32'd1);
        applyStimulus(1'b1, 2'b10, 1'b1);
        checkOutput("basic_cnt2", 32'(sym_count), 32'd2);
        applyStimulus(1'b1, 2'b11, 1'b1);
        checkOutput("basic_cnt3", 32'(sym_count), 32'd3);
        checkOutput("basic_not_yet_valid", 32'(valid_out), 32'd0);
        applyStimulus(1'b1, 2'b00, 1'b1);
        checkOutput("basic_cnt0", 32'(sym_count), 32'd0);
        checkOutput("basic_word", 32'(data_out), 32'h39);
        checkOutput("basic_valid", 32'(valid_out), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("basic_consumed", 32'(valid_out), 32'd0);
        checkOutput("basic_hold_data", 32'(data_out), 32'h39);

        // Gaps between symbols
        doReset();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'((i + 1) % 4);
            applyStimulus(1'b1, s, 1'b1);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(1'b0, 2'($urandom), 1'b1);
                    checkOutput("gap_cnt_hold", 32'(sym_count), 32'(i + 1));
                end
            end
        end
        checkOutput("gap_word", 32'(data_out), 32'h39);
        checkOutput("gap_valid", 32'(valid_out), 32'd1);

        // Back-to-back: hold first word, consume it on the completing edge
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, syms8[i], (i == 3 || i == 7) ? 1'b1 : 1'b0);
            if (i == 3) checkOutput("b2b_word0", 32'(data_out), 32'hE4);
        end
        checkOutput("b2b_word1", 32'(data_out), 32'h1B);
        checkOutput("b2b_no_bubble", 32'(valid_out), 32'd1);
        checkOutput("b2b_no_ovf", 32'(overflow), 32'd0);

        // Overflow: consumer never ready
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, syms8[i], 1'b0);
        checkOutput("ovf_data_kept", 32'(data_out), 32'hE4);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("ovf_consumed", 32'(valid_out), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("ovf_sticky2", 32'(overflow), 32'd1);

        // Reset mid-fill discards partial word
        doReset();
        applyStimulus(1'b1, 2'b11, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b1);
        reset_L = 1'b0;
        #1;
        checkOutput("midrst_cnt", 32'(sym_count), 32'd0);
        checkOutput("midrst_valid", 32'(valid_out), 32'd0);
        checkOutput("midrst_ovf", 32'(overflow), 32'd0);
        checkOutput("midrst_data", 32'(data_out), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 1'b0);
        checkOutput("midrst_word", 32'(data_out), 32'h55);

`ifdef TRANS_COUNT_EN
        // Transition counters
        doReset();
        applyStimulus(1'b1, 2'b11, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b1);
        checkOutput("fall0_const", 32'(fall_cnt0), 32'd2);
        checkOutput("fall1_const", 32'(fall_cnt1), 32'd3);
        doReset();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b1);
            applyStimulus(1'b1, 2'b00, 1'b1);
            if (i == 62) checkOutput("fall0_63", 32'(fall_cnt0), 32'd63);
        end
        checkOutput("fall0_wrap", 32'(fall_cnt0), 32'd0);
`endif

        // Randomized blocks with different consumer readiness
        for (int b = 0; b < 3; b++) begin
            int thresh;
            thresh = (b == 0) ? 90 : ((b == 1) ? 50 : 15);
            doReset();
            for (int i = 0; i < 200; i++) begin
                logic v;
                logic r;
                v = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < thresh);
                applyStimulus(v, 2'($urandom), r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
